// File: rtl/phase_timer_pkg.sv
// Shared constants for the phase timer: phase encoding, phase width and default dwells.
// Consumers: phase_timer (optional pedestrian shortening under PHASE_TIMER_PED_SHORTEN_EN).
package phase_timer_pkg;

    localparam int PHASE_W           = 3;
    localparam int DEF_WIDTH         = 8;
    localparam int DEF_GREEN_TICKS   = 20;
    localparam int DEF_YELLOW_TICKS  = 4;
    localparam int DEF_PED_GREEN_MIN = 5;

    // Even encodings are green, odd encodings are the following yellow.
    typedef enum logic [PHASE_W-1:0] {
        PH_N_G = 3'd0,
        PH_N_Y = 3'd1,
        PH_E_G = 3'd2,
        PH_E_Y = 3'd3,
        PH_S_G = 3'd4,
        PH_S_Y = 3'd5,
        PH_W_G = 3'd6,
        PH_W_Y = 3'd7
    } phase_e;

    function automatic logic is_green(input phase_e p);
        return ~p[0];
    endfunction

endpackage

// File: rtl/phase_down_counter.sv
// Loadable down-counter with enable and zero flag; load wins over enable, and it
// stops at zero rather than wrapping.
module phase_down_counter
    import phase_timer_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/phase_timer.sv
// Traffic phase timer: counts tick-based dwells, steps through 8 green/yellow phases.
// Macro PHASE_TIMER_PED_SHORTEN_EN adds the pedestrian request latch and green clamp.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int GREEN_TICKS   = DEF_GREEN_TICKS,
    parameter int YELLOW_TICKS  = DEF_YELLOW_TICKS,
    parameter int PED_GREEN_MIN = DEF_PED_GREEN_MIN
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               tick,
    input  logic               hold,
    input  logic               ped_req,
    output logic               step,
    output logic [PHASE_W-1:0] phase,
    output logic [WIDTH-1:0]   remaining,
    output logic               ped_pending
);

    // Counter holds "ticks left minus one"; legal range GREEN_TICKS>=2, YELLOW_TICKS>=1,
    // 1<=PED_GREEN_MIN<=GREEN_TICKS, all <= 2**WIDTH.
    localparam logic [WIDTH-1:0] GREEN_RELOAD  = WIDTH'(GREEN_TICKS - 1);
    localparam logic [WIDTH-1:0] YELLOW_RELOAD = WIDTH'(YELLOW_TICKS - 1);

    phase_e           phase_q;
    phase_e           phase_d;
    phase_e           phase_next;
    logic             cnt_en;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_zero;
    logic             expire;

    assign expire     = tick & ~hold & cnt_zero;
    assign phase_next = phase_e'(PHASE_W'(phase_q + 3'd1));

`ifdef PHASE_TIMER_PED_SHORTEN_EN
    localparam logic [WIDTH-1:0] PED_RELOAD = WIDTH'(PED_GREEN_MIN - 1);

    logic ped_q;
    logic clamp_hit;

    assign clamp_hit = ped_q & is_green(phase_q) & (remaining > PED_RELOAD);

    // Clearing on the green-to-yellow step beats a same-cycle request.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ped_q <= 1'b0;
        end else if (expire && is_green(phase_q)) begin
            ped_q <= 1'b0;
        end else if (ped_req) begin
            ped_q <= 1'b1;
        end
    end

    assign ped_pending = ped_q;
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_pending    = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase_q <= PH_N_G;
            step    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            step    <= expire;
        end
    end

    // Hold freezes everything counter-related; expiry reload outranks the clamp.
    always_comb begin
        phase_d      = phase_q;
        cnt_en       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = GREEN_RELOAD;
        if (!hold) begin
            if (tick && cnt_zero) begin
                phase_d      = phase_next;
                cnt_load     = 1'b1;
                cnt_load_val = is_green(phase_next) ? GREEN_RELOAD : YELLOW_RELOAD;
            end
`ifdef PHASE_TIMER_PED_SHORTEN_EN
            else if (clamp_hit) begin
                cnt_load     = 1'b1;
                cnt_load_val = PED_RELOAD;
            end
`endif
            else if (tick) begin
                cnt_en = 1'b1;
            end
        end
    end

    assign phase = phase_q;

    phase_down_counter #(
        .WIDTH     (WIDTH),
        .RESET_VAL (GREEN_RELOAD)
    ) u_counter (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .en       (cnt_en),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .count    (remaining),
        .zero     (cnt_zero)
    );

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer with default parameters; ticks every 4 clocks.
// Pedestrian scenarios follow PHASE_TIMER_PED_SHORTEN_EN.
module tb_phase_timer;
    import phase_timer_pkg::*;

    localparam int WIDTH = 8;

    logic               Clk     = 1'b0;
    logic               Reset_n = 1'b0;
    logic               tick    = 1'b0;
    logic               hold    = 1'b0;
    logic               ped_req = 1'b0;
    logic               step;
    logic [PHASE_W-1:0] phase;
    logic [WIDTH-1:0]   remaining;
    logic               ped_pending;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    always #5 Clk = ~Clk;

    phase_timer #(
        .WIDTH         (8),
        .GREEN_TICKS   (20),
        .YELLOW_TICKS  (4),
        .PED_GREEN_MIN (5)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .tick        (tick),
        .hold        (hold),
        .ped_req     (ped_req),
        .step        (step),
        .phase       (phase),
        .remaining   (remaining),
        .ped_pending (ped_pending)
    );

    // Entered and left at posedge+1; s1/r1 sampled after the tick edge, s2/r2 one clock later.
    task automatic do_tick(output logic s1, output logic s2,
                           output logic [WIDTH-1:0] r1, output logic [WIDTH-1:0] r2);
        tick = 1'b1;
        @(posedge Clk); #1;
        tick = 1'b0;
        s1 = step;
        r1 = remaining;
        @(posedge Clk); #1;
        s2 = step;
        r2 = remaining;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic advance_ticks(input int n);
        logic s1, s2;
        logic [WIDTH-1:0] r1, r2;
        for (int i = 0; i < n; i++) do_tick(s1, s2, r1, r2);
    endtask

    task automatic apply_reset;
        tick = 1'b0; hold = 1'b0; ped_req = 1'b0;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge Clk);
        #1;
        n_tests++;
        if ({step, phase, remaining, ped_pending} !== {1'b0, 3'd0, 8'd19, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_vals: got step=%0d phase=%0d rem=%0d ped=%0d expected 0 0 19 0",
                     step, phase, remaining, ped_pending);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_full_cycle;
        logic s1, s2;
        logic [WIDTH-1:0] r1, r2;
        int   long_steps = 0;
        for (int k = 1; k <= 96; k++)
            if ((k % 24 == 20) || (k % 24 == 0)) exp_q.push_back(8'(k));
        for (int k = 1; k <= 96; k++) begin
            do_tick(s1, s2, r1, r2);
            if (s2) long_steps++;
            if (k == 1) begin
                n_tests++;
                if (r1 !== 8'd18) begin
                    n_fail++; $display("FAIL first_dec: got %0d expected 18", r1);
                end
            end
            if (k == 20) begin
                n_tests++;
                if ({s1, phase, r1} !== {1'b1, 3'd1, 8'd3}) begin
                    n_fail++;
                    $display("FAIL t20_step: got step=%0d phase=%0d rem=%0d expected 1 1 3", s1, phase, r1);
                end
            end
            if (k == 24) begin
                n_tests++;
                if ({s1, phase, r1} !== {1'b1, 3'd2, 8'd19}) begin
                    n_fail++;
                    $display("FAIL t24_step: got step=%0d phase=%0d rem=%0d expected 1 2 19", s1, phase, r1);
                end
            end
            if (s1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL step_unexpected: got step at tick %0d expected none", k);
                end else if (exp_q[0] !== 8'(k)) begin
                    n_fail++;
                    $display("FAIL step_tick: got step at tick %0d expected tick %0d", k, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL steps_missing: got %0d outstanding expected 0", exp_q.size());
        end
        n_tests++;
        if (long_steps != 0) begin
            n_fail++; $display("FAIL step_width: got %0d two-cycle pulses expected 0", long_steps);
        end
        n_tests++;
        if ({phase, remaining} !== {3'd0, 8'd19}) begin
            n_fail++; $display("FAIL wrap: got phase=%0d rem=%0d expected 0 19", phase, remaining);
        end
    endtask

    task automatic test_tick_low;
        int seen = 0;
        apply_reset();
        advance_ticks(3);
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (step) seen++;
        end
        n_tests++;
        if ({seen[7:0], phase, remaining} !== {8'd0, 3'd0, 8'd16}) begin
            n_fail++;
            $display("FAIL tick_low: got steps=%0d phase=%0d rem=%0d expected 0 0 16", seen, phase, remaining);
        end
    endtask

    task automatic test_hold;
        logic s1, s2;
        logic [WIDTH-1:0] r1, r2;
        int seen = 0;
        int first = 0;
        apply_reset();
        advance_ticks(9);
        hold = 1'b1;
        for (int i = 0; i < 12; i++) begin
            do_tick(s1, s2, r1, r2);
            if (s1 || s2) seen++;
        end
        n_tests++;
        if ({seen[7:0], phase, remaining} !== {8'd0, 3'd0, 8'd10}) begin
            n_fail++;
            $display("FAIL hold_freeze: got steps=%0d phase=%0d rem=%0d expected 0 0 10", seen, phase, remaining);
        end
        hold = 1'b0;
        for (int i = 1; i <= 12 && first == 0; i++) begin
            do_tick(s1, s2, r1, r2);
            if (s1) first = i;
        end
        n_tests++;
        if ({first[7:0], phase} !== {8'd11, 3'd1}) begin
            n_fail++;
            $display("FAIL hold_release: got step at tick %0d phase=%0d expected 11 1", first, phase);
        end
    endtask

    task automatic reach_phase2_r15;
        apply_reset();
        advance_ticks(28);
        n_tests++;
        if ({phase, remaining} !== {3'd2, 8'd15}) begin
            n_fail++; $display("FAIL setup_p2: got phase=%0d rem=%0d expected 2 15", phase, remaining);
        end
        ped_req = 1'b1;
        @(posedge Clk); #1;
        ped_req = 1'b0;
    endtask

`ifdef PHASE_TIMER_PED_SHORTEN_EN
    task automatic test_ped_shorten;
        logic s1, s2;
        logic [WIDTH-1:0] r1, r2;
        int first = 0;
        reach_phase2_r15();
        n_tests++;
        if ({ped_pending, remaining} !== {1'b1, 8'd15}) begin
            n_fail++; $display("FAIL ped_latch: got ped=%0d rem=%0d expected 1 15", ped_pending, remaining);
        end
        @(posedge Clk); #1;
        n_tests++;
        if (remaining !== 8'd4) begin
            n_fail++; $display("FAIL ped_clamp: got rem=%0d expected 4", remaining);
        end
        for (int i = 1; i <= 8 && first == 0; i++) begin
            do_tick(s1, s2, r1, r2);
            if (s1) first = i;
        end
        n_tests++;
        if ({first[7:0], phase, ped_pending} !== {8'd5, 3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL ped_end: got tick=%0d phase=%0d ped=%0d expected 5 3 0", first, phase, ped_pending);
        end
    endtask

    task automatic test_ped_yellow;
        logic s1, s2;
        logic [WIDTH-1:0] r1, r2;
        ped_req = 1'b1;
        @(posedge Clk); #1;
        ped_req = 1'b0;
        @(posedge Clk); #1;
        n_tests++;
        if ({ped_pending, phase, remaining} !== {1'b1, 3'd3, 8'd3}) begin
            n_fail++;
            $display("FAIL ped_yellow_hold: got ped=%0d phase=%0d rem=%0d expected 1 3 3",
                     ped_pending, phase, remaining);
        end
        advance_ticks(3);
        do_tick(s1, s2, r1, r2);
        n_tests++;
        if ({s1, phase, r1, r2, ped_pending} !== {1'b1, 3'd4, 8'd19, 8'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL ped_next_green: got step=%0d phase=%0d rem=%0d then %0d ped=%0d expected 1 4 19 4 1",
                     s1, phase, r1, r2, ped_pending);
        end
    endtask
`else
    task automatic test_ped_ignored;
        logic s1, s2;
        logic [WIDTH-1:0] r1, r2;
        int first = 0;
        reach_phase2_r15();
        @(posedge Clk); #1;
        n_tests++;
        if ({ped_pending, remaining} !== {1'b0, 8'd15}) begin
            n_fail++; $display("FAIL ped_off: got ped=%0d rem=%0d expected 0 15", ped_pending, remaining);
        end
        for (int i = 1; i <= 20 && first == 0; i++) begin
            do_tick(s1, s2, r1, r2);
            if (s1) first = i;
        end
        n_tests++;
        if ({first[7:0], phase} !== {8'd16, 3'd3}) begin
            n_fail++; $display("FAIL ped_off_len: got tick=%0d phase=%0d expected 16 3", first, phase);
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic s1, s2;
        logic [WIDTH-1:0] r1, r2;
        int seen = 0;
        apply_reset();
        advance_ticks(69);
        n_tests++;
        if ({phase, remaining} !== {3'd5, 8'd2}) begin
            n_fail++; $display("FAIL setup_p5: got phase=%0d rem=%0d expected 5 2", phase, remaining);
        end
        tick = 1'b1; hold = 1'b1;
        #2;
        Reset_n = 1'b0;
        #1;
        n_tests++;
        if ({step, phase, remaining, ped_pending} !== {1'b0, 3'd0, 8'd19, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got step=%0d phase=%0d rem=%0d ped=%0d expected 0 0 19 0",
                     step, phase, remaining, ped_pending);
        end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (step) seen++;
        end
        n_tests++;
        if ({seen[7:0], phase, remaining} !== {8'd0, 3'd0, 8'd19}) begin
            n_fail++;
            $display("FAIL reset_release: got steps=%0d phase=%0d rem=%0d expected 0 0 19", seen, phase, remaining);
        end
        tick = 1'b0; hold = 1'b0;
        @(posedge Clk); #1;
        do_tick(s1, s2, r1, r2);
        n_tests++;
        if ({s1, r1} !== {1'b0, 8'd18}) begin
            n_fail++; $display("FAIL resume: got step=%0d rem=%0d expected 0 18", s1, r1);
        end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_tick_low();
        test_hold();
`ifdef PHASE_TIMER_PED_SHORTEN_EN
        test_ped_shorten();
        test_ped_yellow();
`else
        test_ped_ignored();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
